// File: rtl/sort_pkg.sv
// Shared definitions for the 4-entry sort sequencer: state encoding, slot count, default width.
// Latency: n/a (package).
// Backpressure: n/a (package).
package sort_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int DEF_WIDTH = 4;

    // State encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SORT = 2'd1;
    localparam logic [1:0] SHOW = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_SORT = SORT,
        S_SHOW = SHOW,
        S_DONE = DONE
    } state_t;

endpackage

// File: rtl/sort_sequencer_btn_edge.sv
// Registered rising-edge detector for a level button input.
// Latency: pulse is high for exactly one cycle, one cycle after btn is first seen high.
// Backpressure: none; a held button yields a single pulse until it is released.
//
// Ports:
//   clk    system clock
//   rst    synchronous active-high reset (clears history and pulse)
//   btn    level button input
//   pulse  one-cycle registered rising-edge pulse
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic btn_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev <= 1'b0;
            pulse    <= 1'b0;
        end else begin
            btn_prev <= btn;
            pulse    <= btn & ~btn_prev;
        end
    end

endmodule

// File: rtl/sort_sequencer.sv
// Loads four operands by one-hot slot select, bubble-sorts them one compare/swap per clock,
// then shows the sorted values on dout for DWELL cycles each, PASSES full rotations.
// Latency: 6 sort cycles + 4*PASSES*DWELL show cycles; buttons ignored while busy (no backpressure).
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   sel       one-hot slot select for loads
//   din       operand to load
//   load_btn  load request (level, rising edge acts)
//   sort_btn  sort request (level, rising edge acts)
//   dout      displayed value (registered)
//   valid     high while dout carries a display value
//   busy      high while sorting or showing
//   done      high once the display sequence has finished
module sort_sequencer
    import sort_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DWELL  = 400,
    parameter int PASSES = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       sel,
    input  logic [WIDTH-1:0] din,
    input  logic             load_btn,
    input  logic             sort_btn,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int KW = $clog2(4 * PASSES);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [KW-1:0] K_LAST     = KW'(4 * PASSES - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

    state_t           state_q;
    logic [WIDTH-1:0] slot_q   [NUM_SLOTS];
    logic [WIDTH-1:0] slot_nxt [NUM_SLOTS];
    logic [1:0]       p_q;
    logic [1:0]       j_q;
    logic [KW-1:0]    k_q;
    logic [DW-1:0]    dwell_q;

    // sel/din are delayed by one cycle so they line up with the registered
    // load pulse: the value written is the one present when the button rose.
    logic [3:0]       sel_q;
    logic [WIDTH-1:0] din_q;

    logic             load_pulse;
    logic             sort_pulse;
    logic             accept_cmd;
    logic             load_fire;
    logic [1:0]       load_idx;
    logic [WIDTH-1:0] cmp_a;
    logic [WIDTH-1:0] cmp_b;
    logic             do_swap;

    btn_edge u_load_edge (
        .clk   (clk),
        .rst   (rst),
        .btn   (load_btn),
        .pulse (load_pulse)
    );

    btn_edge u_sort_edge (
        .clk   (clk),
        .rst   (rst),
        .btn   (sort_btn),
        .pulse (sort_pulse)
    );

    assign accept_cmd = (state_q == S_IDLE) || (state_q == S_DONE);
    assign load_fire  = load_pulse && accept_cmd && $onehot(sel_q);

    always_comb begin
        load_idx = 2'd0;
        case (sel_q)
            4'b0001: load_idx = 2'd0;
            4'b0010: load_idx = 2'd1;
            4'b0100: load_idx = 2'd2;
            4'b1000: load_idx = 2'd3;
            default: load_idx = 2'd0;
        endcase
    end

    // Next slot contents: compare/swap during SORT, operand write in IDLE/DONE.
    // The two never coincide, since loads are only accepted outside SORT.
    always_comb begin
        slot_nxt = slot_q;
        cmp_a    = slot_q[j_q];
        cmp_b    = slot_q[j_q + 2'd1];
        do_swap  = (state_q == S_SORT) && (cmp_a > cmp_b);
        if (do_swap) begin
            slot_nxt[j_q]        = cmp_b;
            slot_nxt[j_q + 2'd1] = cmp_a;
        end
        if (load_fire) begin
            slot_nxt[load_idx] = din_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= '0;
            end
            sel_q   <= '0;
            din_q   <= '0;
            p_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            dwell_q <= '0;
            dout    <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            sel_q  <= sel;
            din_q  <= din;
            slot_q <= slot_nxt;

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (sort_pulse) begin
                        state_q <= S_SORT;
                        p_q     <= '0;
                        j_q     <= '0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end

                S_SORT: begin
                    if (p_q == 2'd2) begin
                        // Last compare (2,0): present its result immediately.
                        state_q <= S_SHOW;
                        k_q     <= '0;
                        dwell_q <= '0;
                        dout    <= slot_nxt[0];
                        valid   <= 1'b1;
                    end else if (j_q == (2'd2 - p_q)) begin
                        p_q <= p_q + 2'd1;
                        j_q <= '0;
                    end else begin
                        j_q <= j_q + 2'd1;
                    end
                end

                S_SHOW: begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_q <= '0;
                        if (k_q == K_LAST) begin
                            state_q <= S_DONE;
                            valid   <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            dout    <= slot_q[NUM_SLOTS-1];
                        end else begin
                            k_q  <= k_q + KW'(1);
                            dout <= slot_q[k_q[1:0] + 2'd1];
                        end
                    end else begin
                        dwell_q <= dwell_q + DW'(1);
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_sequencer.sv
// Directed bench for sort_sequencer with DWELL=4, PASSES=5.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_sort_sequencer;
    import sort_pkg::*;

    localparam int WIDTH  = 4;
    localparam int DWELL  = 4;
    localparam int PASSES = 5;
    localparam int SHOW_CYC = 4 * PASSES * DWELL;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       sel = '0;
    logic [WIDTH-1:0] din = '0;
    logic             load_btn = 1'b0;
    logic             sort_btn = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             valid;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sort_sequencer #(
        .WIDTH  (WIDTH),
        .DWELL  (DWELL),
        .PASSES (PASSES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel),
        .din      (din),
        .load_btn (load_btn),
        .sort_btn (sort_btn),
        .dout     (dout),
        .valid    (valid),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] slots_packed();
        return {dut.slot_q[3], dut.slot_q[2], dut.slot_q[1], dut.slot_q[0]};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; load_btn = 1'b0; sort_btn = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load(input logic [3:0] s, input logic [WIDTH-1:0] d);
        @(negedge clk);
        sel = s; din = d; load_btn = 1'b1;
        @(negedge clk);
        load_btn = 1'b0;
        @(negedge clk);
    endtask

    // exp_v holds the expected sorted slots as {s3,s2,s1,s0}.
    task automatic run_sort(input string name, input logic [15:0] exp_v, input bit with_load,
                            input bit disturb, input bit hold, input int abort_k,
                            input int exp_swaps);
        int         sort_cyc;
        int         swaps;
        int         guard;
        bit         first;
        logic [15:0] cur;
        logic [15:0] prev;
        sort_cyc = 0; swaps = 0; guard = 0; first = 1'b1; prev = '0;

        @(negedge clk);
        sort_btn = 1'b1; load_btn = with_load;
        @(negedge clk);
        if (!hold) sort_btn = 1'b0;
        load_btn = 1'b0;
        @(negedge clk);

        while (!valid && guard < 20) begin
            cur = slots_packed();
            if (busy) begin
                sort_cyc++;
                if (!first && cur != prev) swaps++;
                prev  = cur;
                first = 1'b0;
            end
            if (disturb) begin
                sel = 4'b0001; din = 4'd2;
                load_btn = guard[0];
                sort_btn = ~guard[0];
            end
            guard++;
            @(negedge clk);
        end
        check({name, " sort_cycles"}, 32'(sort_cyc), 32'd6);
        check({name, " show_reached"}, 32'(valid), 32'd1);
        cur = slots_packed();
        if (!first && cur != prev) swaps++;
        check({name, " sorted_slots"}, 32'(cur), 32'(exp_v));
        if (exp_swaps >= 0) check({name, " swap_count"}, 32'(swaps), 32'(exp_swaps));

        for (int i = 0; i < SHOW_CYC; i++) begin
            check({name, " dout"}, 32'(dout), 32'(exp_v[((i / DWELL) % 4) * 4 +: 4]));
            check({name, " valid"}, 32'(valid), 32'd1);
            check({name, " busy"}, 32'(busy), 32'd1);
            if (abort_k >= 0 && i == abort_k * DWELL) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check({name, " rst dout"}, 32'(dout), 32'd0);
                check({name, " rst valid"}, 32'(valid), 32'd0);
                check({name, " rst busy"}, 32'(busy), 32'd0);
                check({name, " rst done"}, 32'(done), 32'd0);
                check({name, " rst slots"}, 32'(slots_packed()), 32'd0);
                check({name, " rst state"}, 32'(dut.state_q), 32'(S_IDLE));
                return;
            end
            if (disturb) begin
                // Stop toggling well before DONE, where loads would be accepted.
                load_btn = (i < SHOW_CYC - 8) ? i[0] : 1'b0;
                sort_btn = (i < SHOW_CYC - 8) ? ~i[0] : 1'b0;
            end
            @(negedge clk);
        end
        check({name, " done"}, 32'(done), 32'd1);
        check({name, " done valid"}, 32'(valid), 32'd0);
        check({name, " done busy"}, 32'(busy), 32'd0);
        check({name, " done dout"}, 32'(dout), 32'(exp_v[15:12]));
        check({name, " done slots"}, 32'(slots_packed()), 32'(exp_v));
    endtask

    initial begin
        // Reset state
        do_reset();
        check("reset dout", 32'(dout), 32'd0);
        check("reset valid", 32'(valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset slots", 32'(slots_packed()), 32'd0);

        // Basic load + sort: 9,3,7,1 -> 1,3,7,9 with 5 swaps
        load(4'b0001, 4'd9);
        load(4'b0010, 4'd3);
        load(4'b0100, 4'd7);
        load(4'b1000, 4'd1);
        check("t1 loaded", 32'(slots_packed()), 32'h1739);
        run_sort("t1", 16'h9731, 1'b0, 1'b0, 1'b0, -1, 5);

        // Re-sort from DONE with button noise throughout: already sorted, ignored inputs
        run_sort("t4", 16'h9731, 1'b0, 1'b1, 1'b0, -1, 0);

        // Illegal selects do not write
        do_reset();
        load(4'b0011, 4'd15);
        load(4'b0000, 4'd15);
        check("t2 slots", 32'(slots_packed()), 32'd0);
        run_sort("t2", 16'h0000, 1'b0, 1'b0, 1'b0, -1, 0);

        // Held load button stores only the value present at its rising edge
        do_reset();
        @(negedge clk);
        sel = 4'b0100; din = 4'd6; load_btn = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            din = 4'(i + 7);
        end
        @(negedge clk);
        load_btn = 1'b0;
        @(negedge clk);
        check("t3 held load", 32'(slots_packed()), 32'h0600);
        // Held sort button: exactly one run, then it stays in DONE
        run_sort("t3", 16'h6000, 1'b0, 1'b0, 1'b1, -1, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3 held sort busy", 32'(busy), 32'd0);
            check("t3 held sort done", 32'(done), 32'd1);
        end
        sort_btn = 1'b0;

        // Reset mid-SHOW at k=7
        do_reset();
        load(4'b0001, 4'd9);
        load(4'b0010, 4'd3);
        load(4'b0100, 4'd7);
        load(4'b1000, 4'd1);
        run_sort("t5", 16'h9731, 1'b0, 1'b0, 1'b0, 7, 5);

        // Same-cycle load+sort: 5,5,2,8 with slot3 overwritten by 0 -> 0,2,5,5.
        // Hand trace: (0,0) eq, then (0,1)(0,2)(1,0)(1,1)(2,0) all swap -> 5 swaps.
        do_reset();
        load(4'b0001, 4'd5);
        load(4'b0010, 4'd5);
        load(4'b0100, 4'd2);
        load(4'b1000, 4'd8);
        check("t6 loaded", 32'(slots_packed()), 32'h8255);
        sel = 4'b1000; din = 4'd0;
        run_sort("t6", 16'h5520, 1'b1, 1'b0, 1'b0, -1, 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
